// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect controller: resolves BEQ/JMP against exceptions, issues a registered
// redirect and holds flush for FLUSH_DEPTH cycles. Optional predictor: define BRANCH_PRED_EN.
module pc_redirect_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_DEPTH  = 2,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_2000,
  parameter int              CNT_W        = 16,
  parameter int              PRED_ENTRIES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             resolve_valid,
  input  logic [6:0]       opcode,
  input  logic             operands_equal,
  input  logic [XLEN-1:0]  branch_pc,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             exc_req,
  output logic             exc_ack,
  output logic [1:0]       pc_src,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
`ifdef BRANCH_PRED_EN
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             predict_taken,
  input  logic             resolve_pred_taken,
`endif
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JMP = 7'b1101111;
  localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            redirect_nx, ack_nx;
  logic [1:0]      src_nx;
  logic [XLEN-1:0] pc_nx;
  logic            is_beq, is_jmp, beq_redirect;
  logic [1:0]      beq_src;
  logic [XLEN-1:0] beq_pc;

  // Decode: anything resolving while flushing is wrong-path; unknown opcodes fall through
  always_comb begin
    is_jmp = 1'b0;
    is_beq = 1'b0;
    if (resolve_valid && state == IDLE) begin
      if (opcode == OP_JMP) is_jmp = 1'b1;
      if (opcode == OP_BEQ) is_beq = 1'b1;
    end
  end

`ifdef BRANCH_PRED_EN
  localparam int IDX_W = $clog2(PRED_ENTRIES);

  logic [1:0]       pred_tbl [PRED_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc_bits;

  assign upd_idx        = branch_pc[IDX_W+1:2];
  assign predict_taken  = pred_tbl[fetch_pc[IDX_W+1:2]][1];
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PRED_ENTRIES; i++) pred_tbl[i] <= 2'b01;
    end else if (is_beq) begin
      if (operands_equal && pred_tbl[upd_idx] != 2'b11)
        pred_tbl[upd_idx] <= pred_tbl[upd_idx] + 2'd1;
      else if (!operands_equal && pred_tbl[upd_idx] != 2'b00)
        pred_tbl[upd_idx] <= pred_tbl[upd_idx] - 2'd1;
    end
  end

  // Only a wrong guess redirects; a wrongly-taken guess returns to the fall-through PC
  always_comb begin
    beq_redirect = is_beq && (operands_equal != resolve_pred_taken);
    beq_src      = operands_equal ? 2'b01 : 2'b00;
    beq_pc       = operands_equal ? branch_target : branch_pc + XLEN'(4);
  end
`else
  logic unused_pred;

  assign unused_pred = ^{branch_pc, PRED_ENTRIES[0]};

  always_comb begin
    beq_redirect = is_beq && operands_equal;
    beq_src      = 2'b01;
    beq_pc       = branch_target;
  end
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    redirect_nx = 1'b0;
    ack_nx      = 1'b0;
    src_nx      = 2'b00;
    pc_nx       = redirect_pc;
    if (exc_req) begin
      redirect_nx = 1'b1;
      ack_nx      = 1'b1;
      src_nx      = 2'b11;
      pc_nx       = EXC_VECTOR;
    end else if (is_jmp) begin
      redirect_nx = 1'b1;
      src_nx      = 2'b10;
      pc_nx       = branch_target;
    end else if (beq_redirect) begin
      redirect_nx = 1'b1;
      src_nx      = beq_src;
      pc_nx       = beq_pc;
    end
    // A new redirect (even mid-flush) restarts the full flush window
    if (redirect_nx) begin
      state_nx = FLUSH;
      cnt_nx   = CW'(FLUSH_DEPTH - 1);
    end else if (state == FLUSH) begin
      if (cnt == '0) state_nx = IDLE;
      else           cnt_nx   = cnt - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      exc_ack        <= 1'b0;
      pc_src         <= 2'b00;
      redirect_pc    <= '0;
      redirect_count <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      redirect_valid <= redirect_nx;
      exc_ack        <= ack_nx;
      pc_src         <= src_nx;
      redirect_pc    <= pc_nx;
      if (redirect_nx && redirect_count != '1)
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl (FLUSH_DEPTH=2, CNT_W=4); predictor scenario
// is included when BRANCH_PRED_EN is defined.
module tb_pc_redirect_ctrl;
  localparam int FD = 2;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JMP = 7'b1101111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic        operands_equal = 1'b0;
  logic [31:0] branch_pc = '0, branch_target = '0;
  logic        exc_req = 1'b0;
  logic        exc_ack, redirect_valid, flush;
  logic [1:0]  pc_src;
  logic [31:0] redirect_pc;
  logic [3:0]  redirect_count;
`ifdef BRANCH_PRED_EN
  logic [31:0] fetch_pc = '0;
  logic        predict_taken;
  logic        resolve_pred_taken = 1'b0;
`endif

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_DEPTH(FD), .EXC_VECTOR(32'h2000), .CNT_W(4),
                     .PRED_ENTRIES(16)) dut (
    .clock(clock), .reset(reset), .resolve_valid(resolve_valid), .opcode(opcode),
    .operands_equal(operands_equal), .branch_pc(branch_pc), .branch_target(branch_target),
    .exc_req(exc_req), .exc_ack(exc_ack), .pc_src(pc_src), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
`ifdef BRANCH_PRED_EN
    .fetch_pc(fetch_pc), .predict_taken(predict_taken), .resolve_pred_taken(resolve_pred_taken),
`endif
    .redirect_count(redirect_count));

  always #5 clock = ~clock;

  typedef struct packed {
    logic rst_n; logic rv; logic [6:0] op; logic eq;
    logic [31:0] bpc; logic [31:0] tgt; logic exc; logic rpt;
  } stim_t;

  typedef struct packed {
    logic ack; logic [1:0] src; logic rv; logic [31:0] rpc; logic fl; logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, errors = 0;
  int   m_rem = 0, m_cnt = 0;
  logic [31:0] m_rpc = '0;
  int   m_tbl[16];

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rst();
    return '0;
  endfunction

  function automatic stim_t jmp(input logic [31:0] tgt);
    stim_t s = idle();
    s.rv = 1'b1; s.op = OP_JMP; s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t beq(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic eq, input logic rpt);
    stim_t s = idle();
    s.rv = 1'b1; s.op = OP_BEQ; s.bpc = pc; s.tgt = tgt; s.eq = eq; s.rpt = rpt;
    return s;
  endfunction

  function automatic stim_t exc(input stim_t base);
    stim_t s = base;
    s.exc = 1'b1;
    return s;
  endfunction

  // Drive one cycle, predict the registered outputs it produces, push them, advance.
  task automatic tick(input stim_t s);
    exp_t e = '0;
    logic redir = 1'b0;
    logic [1:0] src = 2'b00;
    logic is_beq, is_jmp;
    int idx;
    reset = s.rst_n; resolve_valid = s.rv; opcode = s.op; operands_equal = s.eq;
    branch_pc = s.bpc; branch_target = s.tgt; exc_req = s.exc;
`ifdef BRANCH_PRED_EN
    resolve_pred_taken = s.rpt;
`endif
    if (!s.rst_n) begin
      m_rem = 0; m_cnt = 0; m_rpc = '0;
      for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    end else begin
      is_beq = s.rv && (s.op === OP_BEQ) && (m_rem == 0);
      is_jmp = s.rv && (s.op === OP_JMP) && (m_rem == 0);
      if (s.exc) begin
        redir = 1'b1; src = 2'b11; m_rpc = 32'h2000; e.ack = 1'b1;
      end else if (is_jmp) begin
        redir = 1'b1; src = 2'b10; m_rpc = s.tgt;
      end else if (is_beq) begin
`ifdef BRANCH_PRED_EN
        if (s.eq != s.rpt) begin
          redir = 1'b1; src = s.eq ? 2'b01 : 2'b00; m_rpc = s.eq ? s.tgt : s.bpc + 32'd4;
        end
`else
        if (s.eq) begin
          redir = 1'b1; src = 2'b01; m_rpc = s.tgt;
        end
`endif
      end
      if (is_beq) begin
        idx = int'(s.bpc[5:2]);
        if (s.eq && m_tbl[idx] < 3) m_tbl[idx]++;
        else if (!s.eq && m_tbl[idx] > 0) m_tbl[idx]--;
      end
      m_rem = redir ? FD : (m_rem > 0 ? m_rem - 1 : 0);
      if (redir && m_cnt < 15) m_cnt++;
      e.rv = redir; e.src = src; e.rpc = m_rpc; e.fl = (m_rem > 0); e.cnt = 4'(m_cnt);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t e, got;
    st = '{rst(), rst(), idle(), idle(), idle(), idle(), idle()};
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t e, got;
    st = '{beq(32'h0, 32'h40, 1'b1, 1'b0), idle(), idle(), idle(),
           beq(32'h0, 32'h40, 1'b0, 1'b0), idle(), idle()};
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL branch[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_exc_vs_jmp();
    stim_t st[$];
    exp_t e, got;
    st = '{exc(jmp(32'h80)), idle(), idle(), idle()};
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL exc_vs_jmp[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t e, got;
    st = '{jmp(32'h80), exc(beq(32'h8, 32'h44, 1'b1, 1'b0)), idle(), jmp(32'hC0),
           idle(), idle(), exc(idle()), exc(idle()), idle(), idle(), idle()};
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_unknown_opcode();
    stim_t st[$];
    stim_t s;
    exp_t e, got;
    s = idle(); s.rv = 1'b1; s.op = 7'bx; s.eq = 1'b1; s.tgt = 32'h300;
    st = '{s, idle()};
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL unknown_opcode[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    exp_t e, got;
    for (int k = 0; k < 20; k++) begin
      st.push_back(jmp(32'h1000 + 32'(k * 4)));
      st.push_back(idle());
      st.push_back(idle());
    end
    st.push_back(jmp(32'h500));
    st.push_back(rst());
    st.push_back(idle());
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL saturation[%0d]: got %h required %h", i, got, e);
      end
    end
  endtask

`ifdef BRANCH_PRED_EN
  task automatic test_predictor();
    exp_t e, got;
    stim_t s;
    logic want_pred;
    fetch_pc = 32'h100;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0, 3, 4: s = beq(32'h100, 32'h180, 1'b1, m_tbl[0] >= 2);
        5:       s = beq(32'h100, 32'h180, 1'b0, m_tbl[0] >= 2);
        8:       s = beq(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1);
        default: s = idle();
      endcase
      tick(s);
      e = sb.pop_front(); vectors++;
      got = {exc_ack, pc_src, redirect_valid, redirect_pc, flush, redirect_count};
      if (got !== e) begin
        errors++;
        $display("FAIL predictor[%0d]: got %h required %h", i, got, e);
      end
      want_pred = (m_tbl[0] >= 2);
      vectors++;
      if (predict_taken !== want_pred) begin
        errors++;
        $display("FAIL predict_taken[%0d]: got %b required %b", i, predict_taken, want_pred);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    test_reset();
    test_branch();
    test_exc_vs_jmp();
    test_back_to_back();
    test_unknown_opcode();
`ifdef BRANCH_PRED_EN
    test_predictor();
`endif
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
